// File: rtl/board_game_ctrl.sv
// Two-player N-in-a-row board controller: move validation, stone placement,
// and an incremental one-neighbour-per-cycle win/draw scan from the last stone.
module board_game_ctrl #(
    parameter int  BOARD_N = 3,
    parameter int  WIN_LEN = 3,
    parameter int  GRAVITY = 0,
    localparam int IW      = $clog2(BOARD_N),
    localparam int MCW     = $clog2(BOARD_N*BOARD_N+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           new_game,
    input  logic           move_valid,
    input  logic [IW-1:0]  move_row,
    input  logic [IW-1:0]  move_col,
    output logic           move_ready,
    output logic           move_ack,
    output logic           move_err,
    input  logic [IW-1:0]  rd_row,
    input  logic [IW-1:0]  rd_col,
    output logic [1:0]     rd_cell,
    output logic           turn_o,
    output logic [1:0]     game_state,
    output logic [1:0]     winner,
    output logic [MCW-1:0] move_count
);
    localparam int CW = IW + 2;
    localparam int RW = $clog2(WIN_LEN+1);
    localparam logic [IW:0]           N_U     = (IW+1)'(BOARD_N);
    localparam logic signed [CW-1:0]  N_S     = CW'(BOARD_N);
    localparam logic [RW-1:0]         RUN_WIN = RW'(WIN_LEN-1);
    localparam logic [MCW-1:0]        FULL    = MCW'(BOARD_N*BOARD_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           cells [BOARD_N][BOARD_N];
    logic [1:0]           stone;
    logic [IW-1:0]        drop_row, tgt_row, pr, pc;
    logic                 drop_ok, col_in, row_in, tgt_ok;
    logic                 accept, reject;
    logic signed [CW-1:0] cur_r, cur_c, nb_r, nb_c, dr, dc, pos_step, neg_step;
    logic [1:0]           dir;
    logic                 back;
    logic [RW-1:0]        run;
    logic                 nb_in, nb_match, win_hit, last_sweep;

    assign stone      = turn_o ? 2'd2 : 2'd1;
    assign move_ready = (state == S_PLAY);
    assign game_state = state;

    // Target cell: explicit (row, col) or the lowest empty row of the column.
    always_comb begin
        drop_row = '0;
        drop_ok  = 1'b0;
        for (int r = 0; r < BOARD_N; r++) begin
            if (cells[IW'(r)][move_col] == 2'd0) begin
                drop_row = IW'(r);
                drop_ok  = 1'b1;
            end
        end
        col_in = ({1'b0, move_col} < N_U);
        row_in = ({1'b0, move_row} < N_U);
        if (GRAVITY != 0) begin
            tgt_row = drop_row;
            tgt_ok  = col_in && drop_ok;
        end else begin
            tgt_row = move_row;
            tgt_ok  = col_in && row_in && (cells[move_row][move_col] == 2'd0);
        end
    end

    // Neighbour under examination: one step from the cursor along dir, sign set by back.
    always_comb begin
        pos_step = back ? {CW{1'b1}} : CW'(1);
        neg_step = back ? CW'(1) : {CW{1'b1}};
        dr = '0;
        dc = '0;
        case (dir)
            2'd0:    dc = pos_step;
            2'd1:    dr = pos_step;
            2'd2:    begin dr = pos_step; dc = pos_step; end
            default: begin dr = pos_step; dc = neg_step; end
        endcase
        nb_r       = cur_r + dr;
        nb_c       = cur_c + dc;
        nb_in      = !nb_r[CW-1] && !nb_c[CW-1] && (nb_r < N_S) && (nb_c < N_S);
        nb_match   = nb_in && (cells[nb_r[IW-1:0]][nb_c[IW-1:0]] == stone);
        win_hit    = nb_match && (run == RUN_WIN);
        last_sweep = back && (dir == 2'd3);
    end

    always_comb begin
        rd_cell = 2'd0;
        if (({1'b0, rd_row} < N_U) && ({1'b0, rd_col} < N_U))
            rd_cell = cells[rd_row][rd_col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            S_PLAY: begin
                if (move_valid) begin
                    if (tgt_ok) begin
                        accept    = 1'b1;
                        state_nxt = S_CHECK;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (win_hit)
                    state_nxt = S_OVER;
                else if (!nb_match && last_sweep)
                    state_nxt = (move_count == FULL) ? S_OVER : S_PLAY;
            end
            default: ;
        endcase
        // new_game overrides everything, including a simultaneous move
        if (new_game) begin
            state_nxt = S_PLAY;
            accept    = 1'b0;
            reject    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells      <= '{default: 2'd0};
            turn_o     <= 1'b0;
            winner     <= 2'd0;
            move_count <= '0;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
            pr         <= '0;
            pc         <= '0;
            cur_r      <= '0;
            cur_c      <= '0;
            dir        <= 2'd0;
            back       <= 1'b0;
            run        <= '0;
        end else if (new_game) begin
            cells      <= '{default: 2'd0};
            turn_o     <= 1'b0;
            winner     <= 2'd0;
            move_count <= '0;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
        end else begin
            move_ack <= accept;
            move_err <= reject;
            if (accept) begin
                cells[tgt_row][move_col] <= stone;
                move_count <= move_count + 1'b1;
                pr    <= tgt_row;
                pc    <= move_col;
                cur_r <= $signed({2'b00, tgt_row});
                cur_c <= $signed({2'b00, move_col});
                dir   <= 2'd0;
                back  <= 1'b0;
                run   <= RW'(1);
            end else if (state == S_CHECK) begin
                if (nb_match) begin
                    run   <= run + 1'b1;
                    cur_r <= nb_r;
                    cur_c <= nb_c;
                    if (win_hit) winner <= stone;
                end else begin
                    // Sweep over: restart from the placed stone; run spans both halves of a line
                    cur_r <= $signed({2'b00, pr});
                    cur_c <= $signed({2'b00, pc});
                    if (last_sweep) begin
                        if (move_count == FULL) winner <= 2'd3;
                        else                    turn_o <= ~turn_o;
                    end else if (back) begin
                        dir  <= dir + 1'b1;
                        back <= 1'b0;
                        run  <= RW'(1);
                    end else begin
                        back <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_board_game_ctrl.sv
// Bench for board_game_ctrl: a 3x3 free-placement instance and a 7x7 connect-4
// gravity instance, checked against a whole-board reference model.
module tb_board_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       new_game = 1'b0, move_valid = 1'b0;
    logic [2:0] mrow = '0, mcol = '0, rrow = '0, rcol = '0;

    logic       rdy3, ack3, err3, turn3, rdy7, ack7, err7, turn7;
    logic [1:0] cell3, st3, win3, cell7, st7, win7;
    logic [3:0] cnt3;
    logic [5:0] cnt7;

    logic       o_rdy, o_ack, o_err, o_turn;
    logic [1:0] o_cell, o_state, o_win;
    logic [5:0] o_cnt;
    assign o_rdy   = sel ? rdy7  : rdy3;
    assign o_ack   = sel ? ack7  : ack3;
    assign o_err   = sel ? err7  : err3;
    assign o_turn  = sel ? turn7 : turn3;
    assign o_cell  = sel ? cell7 : cell3;
    assign o_state = sel ? st7   : st3;
    assign o_win   = sel ? win7  : win3;
    assign o_cnt   = sel ? cnt7  : {2'b00, cnt3};

    board_game_ctrl dut3 (
        .clk(clk), .rst(rst),
        .new_game(new_game & ~sel), .move_valid(move_valid & ~sel),
        .move_row(mrow[1:0]), .move_col(mcol[1:0]),
        .move_ready(rdy3), .move_ack(ack3), .move_err(err3),
        .rd_row(rrow[1:0]), .rd_col(rcol[1:0]), .rd_cell(cell3),
        .turn_o(turn3), .game_state(st3), .winner(win3), .move_count(cnt3)
    );

    board_game_ctrl #(.BOARD_N(7), .WIN_LEN(4), .GRAVITY(1)) dut7 (
        .clk(clk), .rst(rst),
        .new_game(new_game & sel), .move_valid(move_valid & sel),
        .move_row(mrow), .move_col(mcol),
        .move_ready(rdy7), .move_ack(ack7), .move_err(err7),
        .rd_row(rrow), .rd_col(rcol), .rd_cell(cell7),
        .turn_o(turn7), .game_state(st7), .winner(win7), .move_count(cnt7)
    );

    // Reference model: board contents plus game-level bookkeeping
    int mb [7][7];
    int mstate = 0, mturn = 0, mwin = 0, mcount = 0;
    int total = 0, passed = 0;
    bit last_ack, last_err;

    function automatic bit has_line(input int n, input int w, input int s);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int d = 0; d < 4; d++) begin
                    bit all_s = 1'b1;
                    for (int k = 0; k < w; k++) begin
                        int rr = r + k*dr[d];
                        int cc = c + k*dc[d];
                        if (rr < 0 || rr >= n || cc < 0 || cc >= n) all_s = 1'b0;
                        else if (mb[rr][cc] != s)                    all_s = 1'b0;
                    end
                    if (all_s) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic model_clear(input int st);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) mb[r][c] = 0;
        mturn = 0; mwin = 0; mcount = 0; mstate = st;
    endtask

    task automatic start_game();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
        model_clear(1);
    endtask

    task automatic do_move(input int r, input int c);
        int n, w, tr, s, cyc;
        bit ok, live;
        n = sel ? 7 : 3;
        w = sel ? 4 : 3;
        s = mturn ? 2 : 1;
        live = (mstate == 1);
        tr = -1;
        if (sel) begin
            if (c < n) for (int k = 0; k < n; k++) if (mb[k][c] == 0) tr = k;
            ok = (tr >= 0);
        end else begin
            tr = r;
            ok = (r < n) && (c < n) && (mb[r][c] == 0);
        end
        @(negedge clk); mrow = r[2:0]; mcol = c[2:0]; move_valid = 1'b1;
        @(negedge clk); move_valid = 1'b0;
        last_ack = o_ack; last_err = o_err;
        total++; if (o_ack !== (live && ok))  $display("FAIL move_ack (%0d,%0d): got %b want %b", r, c, o_ack, live && ok); else passed++;
        total++; if (o_err !== (live && !ok)) $display("FAIL move_err (%0d,%0d): got %b want %b", r, c, o_err, live && !ok); else passed++;
        if (live && ok) begin
            mb[tr][c] = s;
            mcount++;
            cyc = 0;
            while (o_state == 2'd2 && cyc < 200) begin @(negedge clk); cyc++; end
            total++; if (cyc > 8*(w-1)+1) $display("FAIL check_len: got %0d cycles, limit %0d", cyc, 8*(w-1)+1); else passed++;
            if (has_line(n, w, s))  begin mstate = 3; mwin = s; end
            else if (mcount == n*n) begin mstate = 3; mwin = 3; end
            else mturn ^= 1;
            rrow = tr[2:0]; rcol = c[2:0]; #1;
            total++; if (o_cell !== s[1:0]) $display("FAIL placed_cell (%0d,%0d): got %0d want %0d", tr, c, o_cell, s); else passed++;
        end
        total++; if (o_state !== mstate[1:0]) $display("FAIL game_state: got %0d want %0d", o_state, mstate); else passed++;
        total++; if (o_win !== mwin[1:0])     $display("FAIL winner: got %0d want %0d", o_win, mwin); else passed++;
        total++; if (o_turn !== mturn[0])     $display("FAIL turn_o: got %0d want %0d", o_turn, mturn); else passed++;
        total++; if (o_cnt !== mcount[5:0])   $display("FAIL move_count: got %0d want %0d", o_cnt, mcount); else passed++;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (st3 !== 2'd0 || st7 !== 2'd0) $display("FAIL reset_state: got %0d/%0d want 0", st3, st7); else passed++;
        total++; if (rdy3 !== 1'b0 || ack3 !== 1'b0 || err3 !== 1'b0) $display("FAIL reset_outputs: got rdy=%b ack=%b err=%b want 0", rdy3, ack3, err3); else passed++;
        total++; if (win3 !== 2'd0 || cnt3 !== 4'd0 || turn3 !== 1'b0) $display("FAIL reset_counters: got win=%0d cnt=%0d turn=%0d want 0", win3, cnt3, turn3); else passed++;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                rrow = 3'(r); rcol = 3'(c); #1;
                total++; if (cell3 !== 2'd0) $display("FAIL reset_cell (%0d,%0d): got %0d want 0", r, c, cell3); else passed++;
            end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_clear(0);
        do_move(0, 0);
    endtask

    task automatic test_win_row();
        sel = 1'b0;
        start_game();
        total++; if (o_rdy !== 1'b1) $display("FAIL ready_in_play: got %b want 1", o_rdy); else passed++;
        do_move(0, 0); do_move(1, 0); do_move(0, 1); do_move(1, 1); do_move(0, 2);
        total++; if (o_state !== 2'd3 || o_win !== 2'd1 || o_cnt !== 6'd5) $display("FAIL row_win: got st=%0d win=%0d cnt=%0d want 3/1/5", o_state, o_win, o_cnt); else passed++;
        total++; if (o_rdy !== 1'b0) $display("FAIL ready_in_over: got %b want 0", o_rdy); else passed++;
        do_move(2, 2);
    endtask

    task automatic test_occupied();
        sel = 1'b0;
        start_game();
        do_move(0, 0);
        do_move(0, 0);
        total++; if (last_err !== 1'b1 || o_cnt !== 6'd1 || o_turn !== 1'b1) $display("FAIL occupied: got err=%b cnt=%0d turn=%0d want 1/1/1", last_err, o_cnt, o_turn); else passed++;
        do_move(3, 0);
        total++; if (last_err !== 1'b1) $display("FAIL out_of_range: got err=%b want 1", last_err); else passed++;
    endtask

    task automatic test_draw();
        int seq[18] = '{0,0, 0,1, 0,2, 1,1, 1,0, 2,0, 1,2, 2,2, 2,1};
        sel = 1'b0;
        start_game();
        for (int i = 0; i < 9; i++) do_move(seq[2*i], seq[2*i+1]);
        total++; if (o_state !== 2'd3 || o_win !== 2'd3 || o_cnt !== 6'd9) $display("FAIL draw: got st=%0d win=%0d cnt=%0d want 3/3/9", o_state, o_win, o_cnt); else passed++;
    endtask

    task automatic test_new_game_collision();
        sel = 1'b0;
        start_game();
        do_move(0, 0); do_move(1, 1);
        @(negedge clk); new_game = 1'b1; move_valid = 1'b1; mrow = 3'd2; mcol = 3'd2;
        @(negedge clk); new_game = 1'b0; move_valid = 1'b0;
        model_clear(1);
        total++; if (o_ack !== 1'b0 || o_err !== 1'b0) $display("FAIL collision_pulse: got ack=%b err=%b want 0", o_ack, o_err); else passed++;
        total++; if (o_state !== 2'd1 || o_cnt !== 6'd0 || o_turn !== 1'b0) $display("FAIL collision_state: got st=%0d cnt=%0d turn=%0d want 1/0/0", o_state, o_cnt, o_turn); else passed++;
        @(negedge clk);
        total++; if (o_ack !== 1'b0 || o_err !== 1'b0) $display("FAIL collision_late: got ack=%b err=%b want 0", o_ack, o_err); else passed++;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                rrow = 3'(r); rcol = 3'(c); #1;
                total++; if (o_cell !== 2'd0) $display("FAIL collision_cell (%0d,%0d): got %0d want 0", r, c, o_cell); else passed++;
            end
    endtask

    task automatic test_rst_mid_check();
        bit seen;
        sel = 1'b0;
        start_game();
        @(negedge clk); mrow = 3'd1; mcol = 3'd1; move_valid = 1'b1;
        @(negedge clk); move_valid = 1'b0;
        total++; if (o_ack !== 1'b1) $display("FAIL midcheck_ack: got %b want 1", o_ack); else passed++;
        @(negedge clk);
        total++; if (o_state !== 2'd2) $display("FAIL midcheck_in_check: got %0d want 2", o_state); else passed++;
        rst = 1'b1; #1;
        model_clear(0);
        total++; if (o_state !== 2'd0 || o_win !== 2'd0 || o_cnt !== 6'd0) $display("FAIL midcheck_rst: got st=%0d win=%0d cnt=%0d want 0", o_state, o_win, o_cnt); else passed++;
        total++; if (o_ack !== 1'b0 || o_err !== 1'b0 || o_rdy !== 1'b0) $display("FAIL midcheck_pulses: got ack=%b err=%b rdy=%b want 0", o_ack, o_err, o_rdy); else passed++;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                rrow = 3'(r); rcol = 3'(c); #1;
                total++; if (o_cell !== 2'd0) $display("FAIL midcheck_cell (%0d,%0d): got %0d want 0", r, c, o_cell); else passed++;
            end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (o_ack || o_err) seen = 1'b1; end
        total++; if (seen !== 1'b0 || o_state !== 2'd0) $display("FAIL midcheck_after: got pulse=%b st=%0d want 0/0", seen, o_state); else passed++;
    endtask

    task automatic test_gravity();
        sel = 1'b1;
        start_game();
        for (int i = 0; i < 4; i++) begin
            do_move(0, 3);
            if (i < 3) do_move(0, 0);
        end
        for (int r = 3; r < 7; r++) begin
            rrow = 3'(r); rcol = 3'd3; #1;
            total++; if (o_cell !== 2'd1) $display("FAIL gravity_stack row %0d: got %0d want 1", r, o_cell); else passed++;
        end
        total++; if (o_win !== 2'd1 || o_state !== 2'd3) $display("FAIL gravity_win: got win=%0d st=%0d want 1/3", o_win, o_state); else passed++;
        start_game();
        for (int i = 0; i < 7; i++) do_move(0, 5);
        do_move(0, 5);
        total++; if (last_err !== 1'b1) $display("FAIL column_full: got err=%b want 1", last_err); else passed++;
        do_move(0, 7);
        total++; if (last_err !== 1'b1) $display("FAIL gravity_col_range: got err=%b want 1", last_err); else passed++;
    endtask

    task automatic test_random_free();
        sel = 1'b0;
        for (int g = 0; g < 8; g++) begin
            int tries = 0;
            start_game();
            while (mstate == 1 && tries < 60) begin
                do_move($urandom_range(0, 3), $urandom_range(0, 3));
                tries++;
            end
            do_move($urandom_range(0, 2), $urandom_range(0, 2));
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    rrow = 3'(r); rcol = 3'(c); #1;
                    total++; if (o_cell !== mb[r][c][1:0]) $display("FAIL rand_board g%0d (%0d,%0d): got %0d want %0d", g, r, c, o_cell, mb[r][c]); else passed++;
                end
        end
    endtask

    task automatic test_random_gravity();
        sel = 1'b1;
        for (int g = 0; g < 3; g++) begin
            int tries = 0;
            start_game();
            while (mstate == 1 && tries < 150) begin
                do_move(0, $urandom_range(0, 7));
                tries++;
            end
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    int e;
                    e = (r < 7 && c < 7) ? mb[r][c] : 0;
                    rrow = 3'(r); rcol = 3'(c); #1;
                    total++; if (o_cell !== e[1:0]) $display("FAIL rand_drop g%0d (%0d,%0d): got %0d want %0d", g, r, c, o_cell, e); else passed++;
                end
        end
    endtask

    initial begin
        test_reset();
        test_win_row();
        test_occupied();
        test_draw();
        test_new_game_collision();
        test_rst_mid_check();
        test_gravity();
        test_random_free();
        test_random_gravity();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "time limit");
    end

endmodule
